// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle control sequencer:
// opcodes, state codes, ALU codes and instruction classes.
package cpu_ctrl_pkg;

   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_LDI  = 5'b00001;
   localparam logic [4:0] OP_ST   = 5'b00010;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_SHR  = 5'b00111;
   localparam logic [4:0] OP_SHRA = 5'b01000;
   localparam logic [4:0] OP_SHL  = 5'b01001;
   localparam logic [4:0] OP_ROR  = 5'b01010;
   localparam logic [4:0] OP_ROL  = 5'b01011;
   localparam logic [4:0] OP_ADDI = 5'b01100;
   localparam logic [4:0] OP_ANDI = 5'b01101;
   localparam logic [4:0] OP_ORI  = 5'b01110;
   localparam logic [4:0] OP_MUL  = 5'b01111;
   localparam logic [4:0] OP_DIV  = 5'b10000;
   localparam logic [4:0] OP_NEG  = 5'b10001;
   localparam logic [4:0] OP_NOT  = 5'b10010;
   localparam logic [4:0] OP_BR   = 5'b10011;
   localparam logic [4:0] OP_JR   = 5'b10100;
   localparam logic [4:0] OP_JAL  = 5'b10101;
   localparam logic [4:0] OP_IN   = 5'b10110;
   localparam logic [4:0] OP_OUT  = 5'b10111;
   localparam logic [4:0] OP_MFHI = 5'b11000;
   localparam logic [4:0] OP_MFLO = 5'b11001;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   localparam logic [4:0] ALU_NONE = 5'b00000;
   localparam logic [4:0] ALU_ADD  = OP_ADD;
   localparam logic [4:0] ALU_AND  = OP_AND;
   localparam logic [4:0] ALU_OR   = OP_OR;

   localparam logic [3:0] S_RST  = 4'd0;
   localparam logic [3:0] S_T0   = 4'd1;
   localparam logic [3:0] S_T1   = 4'd2;
   localparam logic [3:0] S_T2   = 4'd3;
   localparam logic [3:0] S_T3   = 4'd4;
   localparam logic [3:0] S_T4   = 4'd5;
   localparam logic [3:0] S_T5   = 4'd6;
   localparam logic [3:0] S_T6   = 4'd7;
   localparam logic [3:0] S_T7   = 4'd8;
   localparam logic [3:0] S_HALT = 4'd9;

   typedef enum logic [3:0] {
      CL_RALU, CL_UNARY, CL_IALU, CL_MULDIV,
      CL_LDI, CL_LD, CL_ST, CL_BR,
      CL_JR, CL_JAL, CL_IN, CL_OUT,
      CL_MFHI, CL_MFLO, CL_NOP, CL_HALT
   } op_class_e;

   function automatic logic [4:0] ialu_code(
      input logic [4:0] op
   );
      logic [4:0] c;
      c = ALU_ADD;
      if (op == OP_ANDI) c = ALU_AND;
      if (op == OP_ORI)  c = ALU_OR;
      return c;
   endfunction

endpackage

// File: rtl/ctrl_opclass_decode.sv
// Maps a 5-bit opcode to its instruction class and the state
// holding that class's final step. Unknown opcodes act as nop.
module ctrl_opclass_decode
   import cpu_ctrl_pkg::*;
(
   input  logic [4:0] opcode,
   output op_class_e  op_class,
   output logic [3:0] last_state
);

   always_comb begin
      op_class = CL_NOP;
      unique case (1'b1)
         (opcode inside {[OP_ADD:OP_ROL]}):
            op_class = CL_RALU;
         (opcode inside {OP_NEG, OP_NOT}):
            op_class = CL_UNARY;
         (opcode inside {[OP_ADDI:OP_ORI]}):
            op_class = CL_IALU;
         (opcode inside {OP_MUL, OP_DIV}):
            op_class = CL_MULDIV;
         (opcode == OP_LDI):  op_class = CL_LDI;
         (opcode == OP_LD):   op_class = CL_LD;
         (opcode == OP_ST):   op_class = CL_ST;
         (opcode == OP_BR):   op_class = CL_BR;
         (opcode == OP_JR):   op_class = CL_JR;
         (opcode == OP_JAL):  op_class = CL_JAL;
         (opcode == OP_IN):   op_class = CL_IN;
         (opcode == OP_OUT):  op_class = CL_OUT;
         (opcode == OP_MFHI): op_class = CL_MFHI;
         (opcode == OP_MFLO): op_class = CL_MFLO;
         (opcode == OP_HALT): op_class = CL_HALT;
         default:             op_class = CL_NOP;
      endcase
   end

   always_comb begin
      last_state = S_T2;
      case (op_class)
         CL_RALU, CL_IALU, CL_LDI: last_state = S_T5;
         CL_UNARY, CL_JAL:         last_state = S_T4;
         CL_MULDIV, CL_BR:         last_state = S_T6;
         CL_LD, CL_ST:             last_state = S_T7;
         CL_JR, CL_IN, CL_OUT,
         CL_MFHI, CL_MFLO:         last_state = S_T3;
         default:                  last_state = S_T2;
      endcase
   end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control sequencer: fetch T0-T2, execute T3-T7.
// Define CTRL_MEM_WAIT_EN to stall memory states on mem_done.
module control_unit
   import cpu_ctrl_pkg::*;
(
   input  logic       clock,
   input  logic       reset_n,
   input  logic       stop,
   input  logic [4:0] opcode,
   input  logic       con_ff,
   input  logic       mem_done,
   output logic       Gra,
   output logic       Grb,
   output logic       Grc,
   output logic       Rin,
   output logic       Rout,
   output logic       BAout,
   output logic       PCout,
   output logic       PCin,
   output logic       IncPC,
   output logic       IRin,
   output logic       MARin,
   output logic       MDRin,
   output logic       MDRout,
   output logic       Yin,
   output logic       Zin,
   output logic       Zhighout,
   output logic       Zlowout,
   output logic       HIin,
   output logic       HIout,
   output logic       LOin,
   output logic       LOout,
   output logic       Cout,
   output logic       CONin,
   output logic       InPortout,
   output logic       OutPortin,
   output logic       Read,
   output logic       Write,
   output logic [4:0] alu_op,
   output logic       run
);

   logic [3:0] st;
   logic [3:0] st_nx;
   logic [3:0] last_st;
   op_class_e  cls;
   logic       mem_st;
   logic       hold;

   ctrl_opclass_decode u_dec (
      .opcode     (opcode),
      .op_class   (cls),
      .last_state (last_st)
   );

   assign mem_st = (st == S_T1) ||
                   (((st == S_T6) || (st == S_T7)) &&
                    ((cls == CL_LD) || (cls == CL_ST)));

`ifdef CTRL_MEM_WAIT_EN
   assign hold = mem_st && !mem_done;
`else
   logic unused_mem;
   assign unused_mem = mem_done ^ mem_st;
   assign hold = 1'b0;
`endif

   // nop/halt finish in T2, so the opcode is already consulted there
   always_comb begin
      st_nx = st;
      if (st == S_RST)
         st_nx = S_T0;
      else if (st >= S_HALT)
         st_nx = (st == S_HALT) ? S_HALT : S_RST;
      else if (hold)
         st_nx = st;
      else if (st == last_st)
         st_nx = ((cls == CL_HALT) || stop) ? S_HALT : S_T0;
      else
         st_nx = st + 4'd1;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         st <= S_RST;
      else
         st <= st_nx;
   end

   assign run = (st != S_HALT);

   always_comb begin
      Gra = 1'b0; Grb = 1'b0; Grc = 1'b0;
      Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
      PCout = 1'b0; PCin = 1'b0; IncPC = 1'b0;
      IRin = 1'b0; MARin = 1'b0; MDRin = 1'b0;
      MDRout = 1'b0; Yin = 1'b0; Zin = 1'b0;
      Zhighout = 1'b0; Zlowout = 1'b0;
      HIin = 1'b0; HIout = 1'b0;
      LOin = 1'b0; LOout = 1'b0;
      Cout = 1'b0; CONin = 1'b0;
      InPortout = 1'b0; OutPortin = 1'b0;
      Read = 1'b0; Write = 1'b0;
      alu_op = ALU_NONE;
      case (st)
         S_T0: begin
            PCout = 1'b1; MARin = 1'b1;
            IncPC = 1'b1; Zin = 1'b1;
         end
         S_T1: begin
            Zlowout = 1'b1; PCin = 1'b1;
            Read = 1'b1; MDRin = 1'b1;
         end
         S_T2: begin
            MDRout = 1'b1; IRin = 1'b1;
         end
         S_T3: begin
            case (cls)
               CL_RALU, CL_IALU: begin
                  Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
               end
               CL_UNARY: begin
                  Grb = 1'b1; Rout = 1'b1; Zin = 1'b1;
                  alu_op = opcode;
               end
               CL_MULDIV: begin
                  Gra = 1'b1; Rout = 1'b1; Yin = 1'b1;
               end
               CL_LDI, CL_LD, CL_ST: begin
                  Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
               end
               CL_BR: begin
                  Gra = 1'b1; Rout = 1'b1; CONin = 1'b1;
               end
               CL_JR: begin
                  Gra = 1'b1; Rout = 1'b1; PCin = 1'b1;
               end
               CL_JAL: begin
                  PCout = 1'b1; Grb = 1'b1; Rin = 1'b1;
               end
               CL_IN: begin
                  InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1;
               end
               CL_OUT: begin
                  Gra = 1'b1; Rout = 1'b1; OutPortin = 1'b1;
               end
               CL_MFHI: begin
                  HIout = 1'b1; Gra = 1'b1; Rin = 1'b1;
               end
               CL_MFLO: begin
                  LOout = 1'b1; Gra = 1'b1; Rin = 1'b1;
               end
               default: ;
            endcase
         end
         S_T4: begin
            case (cls)
               CL_RALU: begin
                  Grc = 1'b1; Rout = 1'b1; Zin = 1'b1;
                  alu_op = opcode;
               end
               CL_UNARY: begin
                  Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
               end
               CL_IALU: begin
                  Cout = 1'b1; Zin = 1'b1;
                  alu_op = ialu_code(opcode);
               end
               CL_MULDIV: begin
                  Grb = 1'b1; Rout = 1'b1; Zin = 1'b1;
                  alu_op = opcode;
               end
               CL_LDI, CL_LD, CL_ST: begin
                  Cout = 1'b1; Zin = 1'b1;
                  alu_op = ALU_ADD;
               end
               CL_BR: begin
                  PCout = 1'b1; Yin = 1'b1;
               end
               CL_JAL: begin
                  Gra = 1'b1; Rout = 1'b1; PCin = 1'b1;
               end
               default: ;
            endcase
         end
         S_T5: begin
            case (cls)
               CL_RALU, CL_IALU, CL_LDI: begin
                  Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
               end
               CL_MULDIV: begin
                  Zlowout = 1'b1; LOin = 1'b1;
               end
               CL_LD, CL_ST: begin
                  Zlowout = 1'b1; MARin = 1'b1;
               end
               CL_BR: begin
                  Cout = 1'b1; Zin = 1'b1;
                  alu_op = ALU_ADD;
               end
               default: ;
            endcase
         end
         S_T6: begin
            case (cls)
               CL_MULDIV: begin
                  Zhighout = 1'b1; HIin = 1'b1;
               end
               CL_LD: begin
                  Read = 1'b1; MDRin = 1'b1;
               end
               CL_ST: begin
                  Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
               end
               CL_BR: begin
                  Zlowout = 1'b1; PCin = con_ff;
               end
               default: ;
            endcase
         end
         S_T7: begin
            case (cls)
               CL_LD: begin
                  MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1;
               end
               CL_ST: Write = 1'b1;
               default: ;
            endcase
         end
         default: ;
      endcase
   end

endmodule
